kypd_emulator: RTL and testbench



---
 rtl/kypd_emulator.sv | 211 +++++++++++++++++++++
 tb/tb_kypd_emulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kypd_emulator.sv
// 4x4 keypad responder: queued key commands close one contact with bounce; rows answer col drives.
// Rows follow col after row_delay cycles; cmd_ready drops while the command FIFO is full or rst is high.

module kypd_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdat_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdat_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
endmodule

module kypd_emulator #(
  parameter int fifo_depth     = 4,
  parameter int bounce_period  = 8,
  parameter int bounce_toggles = 4,
  parameter int gap_cycles     = 64,
  parameter int row_delay      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [23:0] cmd_hold,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        key_active,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

  localparam logic [23:0] PER_LAST = 24'(bounce_period - 1);
  localparam logic [23:0] TOG_LAST = 24'(bounce_toggles);
  localparam logic [23:0] GAP_LAST = 24'(gap_cycles - 1);
  localparam logic [23:0] GAP_PRE  = 24'(gap_cycles - 2);

  state_t      state_q;
  logic [23:0] cnt_q;
  logic [23:0] tog_q;
  logic [23:0] hold_q;
  logic [3:0]  key_q;
  logic        contact_q;
  logic        done_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [27:0] fifo_rdat;
  logic [3:0]  row_next;
  logic [3:0]  key_pos;
  logic [3:0]  row_pipe_q [row_delay];

  assign cmd_ready  = !fifo_full && !rst;
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign key_active = contact_q;
  assign done       = done_q;
  assign row        = row_pipe_q[row_delay-1];

  kypd_fifo #(.WIDTH(28), .DEPTH(fifo_depth)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && cmd_ready),
    .wdat_i  ({cmd_key, cmd_hold}),
    .pop_i   (fifo_pop),
    .rdat_o  (fifo_rdat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Returns {row index, column index} of a key on the physical layout.
  function automatic logic [3:0] key_to_pos(input logic [3:0] k);
    case (k)
      4'h1: key_to_pos = {2'd0, 2'd0};
      4'h2: key_to_pos = {2'd0, 2'd1};
      4'h3: key_to_pos = {2'd0, 2'd2};
      4'hA: key_to_pos = {2'd0, 2'd3};
      4'h4: key_to_pos = {2'd1, 2'd0};
      4'h5: key_to_pos = {2'd1, 2'd1};
      4'h6: key_to_pos = {2'd1, 2'd2};
      4'hB: key_to_pos = {2'd1, 2'd3};
      4'h7: key_to_pos = {2'd2, 2'd0};
      4'h8: key_to_pos = {2'd2, 2'd1};
      4'h9: key_to_pos = {2'd2, 2'd2};
      4'hC: key_to_pos = {2'd2, 2'd3};
      4'h0: key_to_pos = {2'd3, 2'd0};
      4'hF: key_to_pos = {2'd3, 2'd1};
      4'hE: key_to_pos = {2'd3, 2'd2};
      default: key_to_pos = {2'd3, 2'd3};
    endcase
  endfunction

  assign key_pos = key_to_pos(key_q);

  // Index 0 sits on the MSB of col/row, so the bit position is the inverted index.
  always_comb begin
    row_next = 4'hF;
    if (contact_q && !col[~key_pos[1:0]]) begin
      row_next[~key_pos[3:2]] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < row_delay; i++) row_pipe_q[i] <= 4'hF;
    end else begin
      row_pipe_q[0] <= row_next;
      for (int i = 1; i < row_delay; i++) row_pipe_q[i] <= row_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tog_q     <= '0;
      hold_q    <= 24'd1;
      key_q     <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            key_q     <= fifo_rdat[27:24];
            hold_q    <= (fifo_rdat[23:0] == 24'd0) ? 24'd1 : fifo_rdat[23:0];
            state_q   <= BOUNCE_IN;
            contact_q <= 1'b1;
            cnt_q     <= '0;
            tog_q     <= '0;
          end
        end
        BOUNCE_IN, BOUNCE_OUT: begin
          if (cnt_q == PER_LAST) begin
            cnt_q <= '0;
            if (tog_q == TOG_LAST) begin
              tog_q <= '0;
              if (state_q == BOUNCE_IN) begin
                state_q   <= HOLD;
                contact_q <= 1'b1;
              end else begin
                state_q   <= GAP;
                contact_q <= 1'b0;
                if (gap_cycles == 1) done_q <= 1'b1;
              end
            end else begin
              tog_q     <= tog_q + 24'd1;
              contact_q <= ~contact_q;
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        HOLD: begin
          if (cnt_q == hold_q - 24'd1) begin
            cnt_q     <= '0;
            state_q   <= BOUNCE_OUT;
            contact_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        GAP: begin
          // done is raised one cycle early so the registered pulse lands on the last GAP cycle.
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 24'd1;
            if (cnt_q == GAP_PRE) done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kypd_emulator.sv
// Bench for kypd_emulator: randomized key commands checked against a timeline model of the keypad.
module tb_kypd_emulator;
  localparam int FD = 4, BP = 8, BT = 4, GC = 64, RD = 2;
  localparam int L = (BT + 1) * BP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_key = 4'h0;
  logic [23:0] cmd_hold = 24'd0;
  logic [3:0]  col = 4'hF;
  logic [3:0]  row;
  logic        key_active, busy, done;

  always #5 clk = ~clk;

  kypd_emulator #(.fifo_depth(FD), .bounce_period(BP), .bounce_toggles(BT),
                  .gap_cycles(GC), .row_delay(RD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .col(col), .row(row),
    .key_active(key_active), .busy(busy), .done(done));

  typedef struct { int key; int hold; int acc; } cmd_t;
  typedef struct { int key; int hold; int done_at; } run_t;

  cmd_t exp_q[$];
  run_t done_q[$];
  int tests = 0, fails = 0;
  int cyc = 0;
  bit rst_smp = 0, started = 0;

  // Keypad face, row-major: index = row*4 + column.
  int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  logic [3:0] rot_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int col_mode = 0;
  logic [3:0] col_fixed = 4'hF;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] exp_row_of(input bit contact, input int key, input logic [3:0] cv);
    logic [3:0] v;
    int idx;
    v = 4'hF;
    idx = 0;
    for (int i = 0; i < 16; i++) if (layout[i] == key) idx = i;
    if (contact && cv[3 - idx % 4] == 1'b0) v[3 - idx / 4] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (col_mode)
        0: col = col_fixed;
        1: col = rot_pat[(cyc / 4) % 4];
        default: col = 4'($urandom);
      endcase
    end
  end

  // Reference model state and the monitor that consumes done pulses.
  bit m_active = 0;
  int m_s, m_key, m_hold, m_last_done = -1000;
  int c_err = 0, closed = 0, rises = 0, row_err = 0, gerr = 0;
  int o, start_at;
  bit ce, de, ka_prev = 0, busy_exp, ready_exp;
  logic [3:0] rexp;
  logic [3:0] rn_q[$];
  cmd_t hc;
  run_t rr;

  always @(negedge clk) begin
    if (rst_smp) begin
      started = 1;
      m_active = 0;
      exp_q.delete();
      done_q.delete();
      rn_q.delete();
      repeat (RD) rn_q.push_back(4'hF);
      c_err = 0; closed = 0; rises = 0; ka_prev = 0;
      m_last_done = -1000;
    end
    if (started) begin
      if (!m_active && exp_q.size() > 0) begin
        start_at = exp_q[0].acc + 1;
        if (m_last_done + 2 > start_at) start_at = m_last_done + 2;
        if (cyc >= start_at) begin
          hc = exp_q.pop_front();
          m_active = 1; m_s = cyc; m_key = hc.key; m_hold = hc.hold;
          done_q.push_back('{key: hc.key, hold: hc.hold, done_at: cyc + 2 * L + hc.hold + GC - 1});
          c_err = 0; closed = 0; rises = 0;
        end
      end
      ce = 0; de = 0;
      if (m_active) begin
        o = cyc - m_s;
        if (o < L) ce = ((o / BP) % 2) == 0;
        else if (o < L + m_hold) ce = 1;
        else if (o < 2 * L + m_hold) ce = (((o - L - m_hold) / BP) % 2) == 1;
        else ce = 0;
        de = (o == 2 * L + m_hold + GC - 1);
        if (key_active !== ce) c_err++;
        if (key_active === 1'b1) closed++;
        if (key_active === 1'b1 && ka_prev !== 1'b1) rises++;
      end else if (key_active !== 1'b0) begin
        gerr++;
      end
      ka_prev = key_active;
      rexp = rn_q.pop_front();
      if (row !== rexp) row_err++;
      rn_q.push_back(exp_row_of(ce, m_key, col));
      busy_exp = m_active || exp_q.size() > 0;
      if (busy !== busy_exp) gerr++;
      ready_exp = !rst && exp_q.size() < FD;
      if (cmd_ready !== ready_exp) gerr++;
      if (done === 1'b1) begin
        check("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          rr = done_q.pop_front();
          check($sformatf("done_cycle key%0h", rr.key), cyc, rr.done_at);
          check($sformatf("contact_profile key%0h", rr.key), c_err, 0);
          check($sformatf("closed_cycles key%0h", rr.key), closed, (BT / 2 + 1) * BP + rr.hold + (BT / 2) * BP);
          check($sformatf("contact_rises key%0h", rr.key), rises, 1 + BT);
          check($sformatf("row_senses key%0h", rr.key), row_err, 0);
          row_err = 0;
        end
      end else if (done !== 1'b0 || de) begin
        gerr++;
      end
      if (de) begin
        m_active = 0;
        m_last_done = cyc;
      end
    end
  end

  task automatic push(input int k, input int h);
    int n;
    bit rdy;
    n = 0; rdy = 0;
    cmd_key = k[3:0]; cmd_hold = h[23:0]; cmd_valid = 1'b1;
    while (!rdy && n < 3000) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("push_accepted", rdy, 1);
    if (rdy) exp_q.push_back('{key: k, hold: (h == 0) ? 1 : h, acc: cyc});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() > 0 || done_q.size() > 0 || m_active) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", n < 20000, 1);
    @(posedge clk);
    #1;
  endtask

  int acc_first;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    col_mode = 0; col_fixed = 4'b0111;
    @(negedge clk);
    check("reset_row", row, 4'hF);
    check("reset_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_key_active", key_active, 0);
    check("reset_done", done, 0);
    repeat (100) @(negedge clk);
    check("idle_row", row_err, 0);
    check("idle_status", gerr, 0);
    @(posedge clk); #1;

    col_fixed = 4'b1011;
    push(5, 20);
    wait_idle();

    col_mode = 1;
    push(13, 50);
    wait_idle();

    col_mode = 2;
    push(1, 3); acc_first = cyc;
    push(2, 7); push(3, 0); push(4, 12); push(6, 9);
    check("b2b_accept_span", cyc - acc_first, 4);
    @(negedge clk);
    check("b2b_ready_after5", cmd_ready, 0);
    @(posedge clk); #1;
    wait_idle();

    col_mode = 0; col_fixed = 4'b0111;
    push(1, 200);
    push(9, 5);
    repeat (L + 15) @(posedge clk);
    @(negedge clk);
    check("hold_row_before_rst", row, 4'b0111);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_row", row, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_key_active", key_active, 0);
    repeat (400) @(negedge clk);
    check("post_rst_status", gerr, 0);
    @(posedge clk); #1;

    col_mode = 1;
    push(10, 0);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      col_mode = $urandom_range(0, 2);
      col_fixed = 4'($urandom);
      repeat ($urandom_range(0, 150)) @(posedge clk);
      #1;
      push($urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40));
    end
    wait_idle();

    check("final_row", row_err, 0);
    check("final_status", gerr, 0);
    check("final_pending", done_q.size() + exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
